// File: rtl/evt_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : evt_pkg
//  Purpose   : Shared types and constants for the DVS event byte serializer.
//              The event record layout, the 7-byte frame geometry and the
//              byte-selection helper live here so that the FIFO, the
//              serializer and any future receive side agree on one format.
//  Revision  : 1.0 - initial release
// ============================================================================
package evt_pkg;

  // One event record {p, x, y, t} = 1 + 16 + 16 + 16 bits.
  localparam int EVT_W       = 49;
  localparam int FRAME_BYTES = 7;

  // Upper nibble of frame byte 0; lets a receiver re-align on a byte stream.
  localparam logic [3:0] SYNC_NIBBLE = 4'hA;

  // Byte positions inside a frame (MSB first on the wire).
  localparam logic [2:0] BYTE_SOF  = 3'd0;
  localparam logic [2:0] BYTE_X_HI = 3'd1;
  localparam logic [2:0] BYTE_X_LO = 3'd2;
  localparam logic [2:0] BYTE_Y_HI = 3'd3;
  localparam logic [2:0] BYTE_Y_LO = 3'd4;
  localparam logic [2:0] BYTE_T_HI = 3'd5;
  localparam logic [2:0] BYTE_EOF  = 3'd6;

  typedef struct packed {
    logic        p;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] t;
  } evt_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_t;

  // Byte 'idx' of the frame that carries event 'e'.
  function automatic logic [7:0] frame_byte(input evt_t e, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      BYTE_SOF:  b = {SYNC_NIBBLE, 3'b000, e.p};
      BYTE_X_HI: b = e.x[15:8];
      BYTE_X_LO: b = e.x[7:0];
      BYTE_Y_HI: b = e.y[15:8];
      BYTE_Y_LO: b = e.y[7:0];
      BYTE_T_HI: b = e.t[15:8];
      BYTE_EOF:  b = e.t[7:0];
      default:   b = 8'h00;
    endcase
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/event_byte_serializer_fifo.sv
`default_nettype none
// ============================================================================
//  Module    : event_fifo
//  Purpose   : Small synchronous FIFO holding pending events. Read data is
//              the head entry, presented combinationally (first-word
//              fall-through); rd_en pops it at the clock edge.
//  Ports     : clk, rst_n          clock / async active-low reset
//              wr_en, wr_data      push (ignored while full)
//              rd_en, rd_data      pop (ignored while empty) / head entry
//              full, empty         status flags, derived from registers only
//  Revision  : 1.0 - initial release
// ============================================================================
module event_fifo
  import evt_pkg::*;
#(
  parameter int WIDTH = EVT_W,
  parameter int DEPTH = 4        // power of two, >= 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_ptr_one = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Pointers carry one extra wrap bit: equal -> empty, only MSB differs -> full.
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;

  logic w_do_wr;
  logic w_do_rd;

  assign empty   = (r_wr_ptr == r_rd_ptr);
  assign full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_do_wr = wr_en && !full;
  assign w_do_rd = rd_en && !empty;
  assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

  // Storage needs no reset: pointer reset alone discards the contents.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + c_ptr_one;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/event_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module    : event_byte_serializer
//  Purpose   : Accepts filtered DVS events (x,y,t,p), queues them in a small
//              FIFO and sends each as a 7-byte frame on an 8-bit valid/ready
//              byte stream: {A,000,p} x_hi x_lo y_hi y_lo t_hi t_lo.
//  Ports     : clk, rst_n                       clock / async active-low reset
//              ev_valid, ev_ready               event input handshake
//              ev_x, ev_y, ev_t, ev_p           event fields
//              tx_data, tx_valid, tx_ready      byte output handshake
//              tx_sof, tx_eof                   first / last byte of a frame
//              busy                             frame in flight or events queued
//              drop_count                       saturating overflow count
//  Revision  : 1.0 - initial release
// ============================================================================
module event_byte_serializer
  import evt_pkg::*;
#(
  parameter int FIFO_DEPTH   = 4,     // power of two, >= 2
  parameter bit DROP_ON_FULL = 1'b0,  // 1: never backpressure, drop and count instead
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ev_valid,
  output logic             ev_ready,
  input  logic [15:0]      ev_x,
  input  logic [15:0]      ev_y,
  input  logic [15:0]      ev_t,
  input  logic             ev_p,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             tx_sof,
  output logic             tx_eof,
  output logic             busy,
  output logic [CNT_W-1:0] drop_count
);

  // --------------------------------------------------------------------------
  // Event FIFO
  // --------------------------------------------------------------------------
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_fifo_wr_en;
  logic             w_fifo_rd_en;
  logic [EVT_W-1:0] w_wr_evt;
  logic [EVT_W-1:0] w_head;

  assign w_wr_evt     = {ev_p, ev_x, ev_y, ev_t};
  // In both modes an event is stored only if there is room; in backpressure
  // mode ev_ready already equals !full so the extra term is redundant there.
  assign w_fifo_wr_en = ev_valid && !w_fifo_full;

  event_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (w_fifo_wr_en),
    .wr_data (w_wr_evt),
    .rd_en   (w_fifo_rd_en),
    .rd_data (w_head),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

  // --------------------------------------------------------------------------
  // Serializer FSM
  // --------------------------------------------------------------------------
  ser_state_t r_state;
  evt_t       r_frame;       // event currently on the wire
  logic [2:0] r_byte_idx;
  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       r_tx_sof;
  logic       r_tx_eof;

  logic       w_tx_fire;
  logic       w_last_byte;
  logic [2:0] w_next_idx;

  assign w_tx_fire   = r_tx_valid && tx_ready;
  assign w_last_byte = (r_byte_idx == BYTE_EOF);
  assign w_next_idx  = r_byte_idx + 3'd1;

  // Pop when idle, or on the final byte handshake so the next frame follows
  // without a bubble cycle.
  assign w_fifo_rd_en = !w_fifo_empty &&
                        ((r_state == ST_IDLE) || (w_tx_fire && w_last_byte));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_frame    <= '0;
      r_byte_idx <= BYTE_SOF;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_tx_sof   <= 1'b0;
      r_tx_eof   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fifo_rd_en) begin
            r_state    <= ST_SEND;
            r_frame    <= w_head;
            r_byte_idx <= BYTE_SOF;
            r_tx_data  <= frame_byte(w_head, BYTE_SOF);
            r_tx_valid <= 1'b1;
            r_tx_sof   <= 1'b1;
            r_tx_eof   <= 1'b0;
          end
        end

        ST_SEND: begin
          // Outputs only move on a handshake, so they hold while stalled.
          if (w_tx_fire) begin
            if (w_last_byte) begin
              if (w_fifo_rd_en) begin
                r_frame    <= w_head;
                r_byte_idx <= BYTE_SOF;
                r_tx_data  <= frame_byte(w_head, BYTE_SOF);
                r_tx_sof   <= 1'b1;
                r_tx_eof   <= 1'b0;
              end else begin
                r_state    <= ST_IDLE;
                r_byte_idx <= BYTE_SOF;
                r_tx_valid <= 1'b0;
                r_tx_sof   <= 1'b0;
                r_tx_eof   <= 1'b0;
              end
            end else begin
              r_byte_idx <= w_next_idx;
              r_tx_data  <= frame_byte(r_frame, w_next_idx);
              r_tx_sof   <= 1'b0;
              r_tx_eof   <= (w_next_idx == BYTE_EOF);
            end
          end
        end

        default: begin
          r_state    <= ST_IDLE;
          r_tx_valid <= 1'b0;
          r_tx_sof   <= 1'b0;
          r_tx_eof   <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign tx_sof   = r_tx_sof;
  assign tx_eof   = r_tx_eof;
  assign busy     = (r_state == ST_SEND) || !w_fifo_empty;

  // --------------------------------------------------------------------------
  // Input flow control / drop counter
  // --------------------------------------------------------------------------
  generate
    if (DROP_ON_FULL) begin : g_drop
      logic [CNT_W-1:0] r_drop_count;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_drop_count <= '0;
        end else if (ev_valid && w_fifo_full && (r_drop_count != {CNT_W{1'b1}})) begin
          r_drop_count <= r_drop_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end

      assign ev_ready   = 1'b1;
      assign drop_count = r_drop_count;
    end else begin : g_backpressure
      // Depends only on FIFO pointers: no combinational path from tx_ready,
      // so a slot freed by a pop is only offered on the following cycle.
      assign ev_ready   = !w_fifo_full;
      assign drop_count = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_event_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module    : tb_event_byte_serializer
//  Purpose   : Directed self-checking bench. Instance u_bp runs with
//              backpressure, instance u_drop with DROP_ON_FULL=1.
//  Revision  : 1.0 - initial release
// ============================================================================
module tb_event_byte_serializer;

  logic        clk;
  logic        rst_n;

  logic        ev_valid, ev_ready, ev_p;
  logic [15:0] ev_x, ev_y, ev_t;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready, tx_sof, tx_eof, busy;
  logic [7:0]  drop_count;

  logic        ev_valid1, ev_ready1, ev_p1;
  logic [15:0] ev_x1, ev_y1, ev_t1;
  logic [7:0]  tx_data1;
  logic        tx_valid1, tx_ready1, tx_sof1, tx_eof1, busy1;
  logic [7:0]  drop_count1;

  int vectors;
  int miscompares;

  logic [48:0] evtab [7];   // {p, x, y, t}
  logic [7:0]  single_exp [7];

  event_byte_serializer #(.FIFO_DEPTH(4), .DROP_ON_FULL(1'b0), .CNT_W(8)) u_bp (
    .clk(clk), .rst_n(rst_n),
    .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_x(ev_x), .ev_y(ev_y), .ev_t(ev_t), .ev_p(ev_p),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_sof(tx_sof), .tx_eof(tx_eof), .busy(busy), .drop_count(drop_count)
  );

  event_byte_serializer #(.FIFO_DEPTH(4), .DROP_ON_FULL(1'b1), .CNT_W(8)) u_drop (
    .clk(clk), .rst_n(rst_n),
    .ev_valid(ev_valid1), .ev_ready(ev_ready1),
    .ev_x(ev_x1), .ev_y(ev_y1), .ev_t(ev_t1), .ev_p(ev_p1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1),
    .tx_sof(tx_sof1), .tx_eof(tx_eof1), .busy(busy1), .drop_count(drop_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame byte k of event e, built straight from the wire format.
  function automatic logic [7:0] exp_byte(input logic [48:0] e, input int k);
    logic [55:0] f;
    f = {4'hA, 3'b000, e};
    return f[55 - 8*k -: 8];
  endfunction

  task automatic drive_bp(input logic [48:0] e);
    ev_p = e[48]; ev_x = e[47:32]; ev_y = e[31:16]; ev_t = e[15:0];
    ev_valid = 1'b1;
  endtask

  task automatic drive_drop(input logic [48:0] e);
    ev_p1 = e[48]; ev_x1 = e[47:32]; ev_y1 = e[31:16]; ev_t1 = e[15:0];
    ev_valid1 = 1'b1;
  endtask

  // --------------------------------------------------------------------------
  task automatic test_reset;
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || ev_ready !== 1'b1 || tx_data !== 8'h00 ||
        tx_sof !== 1'b0 || tx_eof !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: valid=%b busy=%b ready=%b data=%h sof=%b eof=%b, required 0 0 1 00 0 0",
               tx_valid, busy, ev_ready, tx_data, tx_sof, tx_eof);
    end
    vectors++;
    if (drop_count1 !== 8'd0 || ev_ready1 !== 1'b1 || drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_drop: drop1=%0d ready1=%b drop=%0d, required 0 1 0",
               drop_count1, ev_ready1, drop_count);
    end
    // Start a frame, then reset asynchronously in the middle of it.
    tx_ready = 1'b1;
    drive_bp(single_exp_evt());
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL midframe_active: tx_valid=%b, required 1", tx_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0 || ev_ready !== 1'b1 || drop_count1 !== 8'd0 ||
        tx_data !== 8'h00 || tx_sof !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: valid=%b busy=%b ready=%b drop1=%0d data=%h sof=%b, required 0 0 1 0 00 0",
               tx_valid, busy, ev_ready, drop_count1, tx_data, tx_sof);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: valid=%b busy=%b, required 0 0", tx_valid, busy);
    end
  endtask

  function automatic logic [48:0] single_exp_evt();
    return {1'b1, 16'h1234, 16'h00AB, 16'hBEEF};
  endfunction

  // --------------------------------------------------------------------------
  task automatic test_single;
    tx_ready = 1'b1;
    drive_bp(single_exp_evt());
    @(negedge clk);            // accept edge E0 has passed
    ev_valid = 1'b0;
    vectors++;
    if (tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency: tx_valid=%b one edge after accept, required 0", tx_valid);
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      vectors++;
      if (tx_valid !== 1'b1 || tx_data !== single_exp[k] ||
          tx_sof !== (k == 0) || tx_eof !== (k == 6)) begin
        miscompares++;
        $display("FAIL single_byte%0d: valid=%b data=%h sof=%b eof=%b, required 1 %h %b %b",
                 k, tx_valid, tx_data, tx_sof, tx_eof, single_exp[k], (k == 0), (k == 6));
      end
    end
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_end: valid=%b busy=%b, required 0 0", tx_valid, busy);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_backpressure;
    int         k;
    logic       stalled;
    logic [7:0] held;
    k = 0; stalled = 1'b0; held = 8'h00;
    tx_ready = 1'b0;
    drive_bp(single_exp_evt());
    @(negedge clk);
    ev_valid = 1'b0;
    for (int cyc = 0; cyc < 300 && k < 7; cyc++) begin
      @(negedge clk);
      if (stalled) begin
        vectors++;
        if (tx_valid !== 1'b1 || tx_data !== held) begin
          miscompares++;
          $display("FAIL bp_stall_hold: valid=%b data=%h, required 1 %h", tx_valid, tx_data, held);
        end
      end
      tx_ready = 1'($urandom_range(0, 1));
      if (tx_valid && tx_ready) begin
        vectors++;
        if (tx_data !== single_exp[k]) begin
          miscompares++;
          $display("FAIL bp_byte%0d: data=%h, required %h", k, tx_data, single_exp[k]);
        end
        k++;
        stalled = 1'b0;
      end else begin
        stalled = tx_valid;
        held    = tx_data;
      end
    end
    vectors++;
    if (k != 7) begin
      miscompares++;
      $display("FAIL bp_timeout: %0d bytes, required 7", k);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_no_dup: tx_valid=%b after frame, required 0", tx_valid);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_full;
    int k;
    tx_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_bp(evtab[i]);
      #1;
      vectors++;
      if (ev_ready !== (i < 5)) begin
        miscompares++;
        $display("FAIL full_ready_ev%0d: ev_ready=%b, required %b", i, ev_ready, (i < 5));
      end
      @(negedge clk);
    end
    ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (tx_valid !== 1'b1 || tx_data !== exp_byte(evtab[0], 0) || busy !== 1'b1 || ev_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_stalled: valid=%b data=%h busy=%b ready=%b, required 1 %h 1 0",
               tx_valid, tx_data, busy, ev_ready, exp_byte(evtab[0], 0));
    end
    tx_ready = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 100 && k < 35; cyc++) begin
      if (tx_valid) begin
        vectors++;
        if (tx_data !== exp_byte(evtab[k/7], k%7) || tx_sof !== (k%7 == 0)) begin
          miscompares++;
          $display("FAIL full_byte%0d: data=%h sof=%b, required %h %b",
                   k, tx_data, tx_sof, exp_byte(evtab[k/7], k%7), (k%7 == 0));
        end
        k++;
      end
      @(negedge clk);
    end
    vectors++;
    if (k != 35 || tx_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL full_drain: bytes=%0d valid=%b busy=%b, required 35 0 0", k, tx_valid, busy);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_drop;
    int k;
    tx_ready1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive_drop(evtab[i]);
      #1;
      vectors++;
      if (ev_ready1 !== 1'b1) begin
        miscompares++;
        $display("FAIL drop_ready_ev%0d: ev_ready=%b, required 1", i, ev_ready1);
      end
      @(negedge clk);
    end
    ev_valid1 = 1'b0;
    vectors++;
    if (drop_count1 !== 8'd2) begin
      miscompares++;
      $display("FAIL drop_count2: drop_count=%0d, required 2", drop_count1);
    end
    ev_valid1 = 1'b1;
    repeat (100) @(negedge clk);
    vectors++;
    if (drop_count1 !== 8'd102) begin
      miscompares++;
      $display("FAIL drop_count102: drop_count=%0d, required 102", drop_count1);
    end
    repeat (153) @(negedge clk);
    vectors++;
    if (drop_count1 !== 8'd255) begin
      miscompares++;
      $display("FAIL drop_count255: drop_count=%0d, required 255", drop_count1);
    end
    repeat (47) @(negedge clk);
    ev_valid1 = 1'b0;
    vectors++;
    if (drop_count1 !== 8'd255) begin
      miscompares++;
      $display("FAIL drop_saturate: drop_count=%0d, required 255", drop_count1);
    end
    tx_ready1 = 1'b1;
    k = 0;
    for (int cyc = 0; cyc < 100 && k < 35; cyc++) begin
      if (tx_valid1) begin
        vectors++;
        if (tx_data1 !== exp_byte(evtab[k/7], k%7)) begin
          miscompares++;
          $display("FAIL drop_byte%0d: data=%h, required %h", k, tx_data1, exp_byte(evtab[k/7], k%7));
        end
        k++;
      end
      @(negedge clk);
    end
    vectors++;
    if (k != 35 || tx_valid1 !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_drain: bytes=%0d valid=%b, required 35 0", k, tx_valid1);
    end
  endtask

  // --------------------------------------------------------------------------
  task automatic test_back_to_back;
    int   run;
    logic seen;
    tx_ready = 1'b1;
    drive_bp(evtab[2]);
    @(negedge clk);
    drive_bp(evtab[3]);
    @(negedge clk);
    ev_valid = 1'b0;
    run = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (tx_valid !== 1'b1) break;
      vectors++;
      if (tx_data !== exp_byte(evtab[2 + run/7], run%7) ||
          tx_sof !== (run%7 == 0) || tx_eof !== (run%7 == 6)) begin
        miscompares++;
        $display("FAIL b2b_byte%0d: data=%h sof=%b eof=%b, required %h %b %b",
                 run, tx_data, tx_sof, tx_eof, exp_byte(evtab[2 + run/7], run%7),
                 (run%7 == 0), (run%7 == 6));
      end
      run++;
      @(negedge clk);
    end
    vectors++;
    if (run != 14) begin
      miscompares++;
      $display("FAIL b2b_contiguous: %0d valid cycles, required 14", run);
    end
    // Reset just after byte 3 of the first frame is taken.
    drive_bp(evtab[4]);
    @(negedge clk);
    drive_bp(evtab[5]);
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (3) @(negedge clk);   // B3 now on the bus
    @(posedge clk);              // B3 handshake
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (tx_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_reset: valid=%b busy=%b, required 0 0", tx_valid, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (tx_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL b2b_residual: output activity after reset, required none");
    end
  endtask

  // --------------------------------------------------------------------------
  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0;
    ev_valid = 1'b0; ev_x = '0; ev_y = '0; ev_t = '0; ev_p = 1'b0; tx_ready = 1'b1;
    ev_valid1 = 1'b0; ev_x1 = '0; ev_y1 = '0; ev_t1 = '0; ev_p1 = 1'b0; tx_ready1 = 1'b1;
    evtab[0] = {1'b0, 16'h0001, 16'h0002, 16'h0003};
    evtab[1] = {1'b1, 16'hA5A5, 16'h5A5A, 16'hFFFF};
    evtab[2] = {1'b0, 16'h1357, 16'h2468, 16'h9ACE};
    evtab[3] = {1'b1, 16'hFEDC, 16'hBA98, 16'h7654};
    evtab[4] = {1'b0, 16'h0F0F, 16'hF0F0, 16'h00FF};
    evtab[5] = {1'b1, 16'h8001, 16'h4002, 16'h2004};
    evtab[6] = {1'b0, 16'hDEAD, 16'hC0DE, 16'hCAFE};
    single_exp[0] = 8'hA1; single_exp[1] = 8'h12; single_exp[2] = 8'h34;
    single_exp[3] = 8'h00; single_exp[4] = 8'hAB; single_exp[5] = 8'hBE;
    single_exp[6] = 8'hEF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_full();
    test_drop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
